// File: rtl/apb_regbank_pkg.sv
// ----------------------------------------------------------------------------
// apb_regbank_pkg
// Shared definitions for the APB register bank.
//   state_t : transfer FSM states (idle / access phase)
//   CNT_W   : width of the access-phase wait-state counter
// ----------------------------------------------------------------------------
package apb_regbank_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/apb_regbank_decode.sv
// ----------------------------------------------------------------------------
// apb_regbank_decode
// Combinational address/attribute decode for the APB register bank.
// Optional feature macro: APB_REGBANK_PROT_CHECK_EN (non-secure accesses to
// the upper half of the register space are rejected).
// Ports:
//   paddr    in  AW          byte address
//   pwrite   in  1           transfer direction
//   pprot    in  3           APB protection attributes
//   idx      out log2(NREGS) register index
//   oor      out 1           address bits above the index are nonzero
//   ro_err   out 1           write aimed at the read-only status register
//   prot_err out 1           protection violation (always 0 when disabled)
// ----------------------------------------------------------------------------
module apb_regbank_decode
    import apb_regbank_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int NREGS = 16
) (
    input  logic [AW-1:0]              paddr,
    input  logic                       pwrite,
    input  logic [2:0]                 pprot,
    output logic [$clog2(NREGS)-1:0]   idx,
    output logic                       oor,
    output logic                       ro_err,
    output logic                       prot_err
);

    localparam int BW = $clog2(DW / 8);
    localparam int IW = $clog2(NREGS);
    localparam int HI = BW + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    assign idx = paddr[HI-1:BW];

    // Sub-word byte offset is irrelevant: accesses are always whole registers.
    logic unused_sub;
    assign unused_sub = ^paddr[BW-1:0];

    generate
        if (HI < AW) begin : g_oor
            assign oor = |paddr[AW-1:HI];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    // The last register mirrors live status and cannot be written.
    assign ro_err = pwrite & (idx == LAST_IDX);

`ifdef APB_REGBANK_PROT_CHECK_EN
    // Upper half of the index space is secure-only; PPROT[1]=1 means non-secure.
    assign prot_err = pprot[1] & idx[IW-1];
    logic unused_prot;
    assign unused_prot = pprot[0] ^ pprot[2];
`else
    assign prot_err = 1'b0;
    logic unused_prot;
    assign unused_prot = ^pprot;
`endif

endmodule

// File: rtl/apb_regbank.sv
// ----------------------------------------------------------------------------
// apb_regbank
// APB slave register bank with configurable wait states. NREGS-1 writable
// registers plus a read-only live-status register at index NREGS-1.
// Optional feature macro: APB_REGBANK_PROT_CHECK_EN (see apb_regbank_decode).
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB/PPROT   APB request
//   PREADY/PRDATA/PSLVERR  APB response (valid on the completion cycle only)
//   regs_o                 flattened register contents, reg i at [i*DW +: DW]
//   sts_i                  live status, read back at index NREGS-1
//   wr_pulse_o             one-cycle strobe per register after a committed write
// ----------------------------------------------------------------------------
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int NREGS = 16,
    parameter int WAIT  = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [AW-1:0]         PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DW-1:0]         PWDATA,
    input  logic [DW/8-1:0]       PSTRB,
    input  logic [2:0]            PPROT,
    output logic                  PREADY,
    output logic [DW-1:0]         PRDATA,
    output logic                  PSLVERR,
    output logic [NREGS*DW-1:0]   regs_o,
    input  logic [DW-1:0]         sts_i,
    output logic [NREGS-1:0]      wr_pulse_o
);

    localparam int IW = $clog2(NREGS);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NREGS - 1);
    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DW-1:0]           regs_reg [NREGS];
    logic [NREGS-1:0]        wr_pulse_reg;

    logic [IW-1:0]           idx;
    logic                    oor;
    logic                    ro_err;
    logic                    prot_err;
    logic                    err;
    logic                    ready;
    logic                    commit;

    apb_regbank_decode #(
        .AW    (AW),
        .DW    (DW),
        .NREGS (NREGS)
    ) u_decode (
        .paddr    (PADDR),
        .pwrite   (PWRITE),
        .pprot    (PPROT),
        .idx      (idx),
        .oor      (oor),
        .ro_err   (ro_err),
        .prot_err (prot_err)
    );

    assign err    = oor | ro_err | prot_err;
    assign ready  = (state_reg == ST_ACCESS) && (cnt_reg == '0) && PSEL && PENABLE;
    assign commit = ready & PWRITE & ~err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            wr_pulse_reg <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            wr_pulse_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_reg <= ST_ACCESS;
                        cnt_reg   <= WAIT_CNT;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        // Master dropped the transfer: abandon without side effects.
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else if (ready) begin
                        state_reg <= ST_IDLE;
                        if (commit) begin
                            for (int b = 0; b < DW / 8; b++) begin
                                if (PSTRB[b]) begin
                                    regs_reg[idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
                                end
                            end
                            // Pulse even with all strobes low: the write still committed.
                            wr_pulse_reg[idx] <= 1'b1;
                        end
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        if (ready && !PWRITE && !err) begin
            PRDATA = (idx == LAST_IDX) ? sts_i : regs_reg[idx];
        end
    end

    assign PREADY     = ready;
    assign PSLVERR    = ready & err;
    assign wr_pulse_o = wr_pulse_reg;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs_out
            assign regs_o[gi*DW +: DW] = regs_reg[gi];
        end
    endgenerate

endmodule
